pipe_ctrl_unit: RTL and testbench

- Parametrised successor to the single-stage decoder. Decodes the ID-stage instruction into a control word and carries that word through STAGES registered pipeline stages (EX, MEM, WB, ...).
- Applies cache freeze, load-use bubble and branch flush to the control pipeline.
- Sequences HLT through a drain state machine.
- Sits between the IF/ID latch and the datapath; the datapath consumes one control slice per stage.

---
 rtl/pipe_ctrl_pkg.sv | 43 ++++
 rtl/pipe_ctrl_unit_if.sv | 43 ++++
 rtl/ctrl_decode.sv | 90 +++++++++
 rtl/pipe_ctrl_unit.sv | 95 +++++++++
 tb/tb_pipe_ctrl_unit.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared control-word layout, halt-state encoding and ISA opcode/func values
// for the pipelined control unit.
package pipe_ctrl_pkg;

    // Control word: {valid, hlt, wwd, reg_write, mem_to_reg, mem_read, mem_write,
    //                reg_dst[1:0], alu_op[1:0], alu_src}
    localparam int CW           = 12;
    localparam int CTRL_VALID   = 11;
    localparam int CTRL_HLT     = 10;
    localparam int CTRL_WWD     = 9;
    localparam int CTRL_REGWR   = 8;
    localparam int CTRL_MEM2REG = 7;
    localparam int CTRL_MEMRD   = 6;
    localparam int CTRL_MEMWR   = 5;
    localparam int CTRL_REGDST  = 3;   // 2-bit field [4:3]
    localparam int CTRL_ALUOP   = 1;   // 2-bit field [2:1]
    localparam int CTRL_ALUSRC  = 0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } halt_state_e;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_OR   = 2'b01;
    localparam logic [1:0] ALU_LHI  = 2'b10;
    localparam logic [1:0] ALU_FUNC = 2'b11;

    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R2  = 2'b10;

    // ISA encodings mirrored from opcodes.v
    localparam logic [3:0] OP_BNE = 4'd0,  OP_BEQ = 4'd1,  OP_BGZ = 4'd2,  OP_BLZ = 4'd3;
    localparam logic [3:0] OP_ADI = 4'd4,  OP_ORI = 4'd5,  OP_LHI = 4'd6,  OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8,  OP_JMP = 4'd9,  OP_JAL = 4'd10, OP_RTYPE = 4'd15;

    localparam logic [5:0] FN_ADD = 6'd0,  FN_SUB = 6'd1,  FN_AND = 6'd2,  FN_ORR = 6'd3;
    localparam logic [5:0] FN_NOT = 6'd4,  FN_TCP = 6'd5,  FN_SHL = 6'd6,  FN_SHR = 6'd7;
    localparam logic [5:0] FN_JPR = 6'd25, FN_JRL = 6'd26, FN_WWD = 6'd28, FN_HLT = 6'd29;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// ID-side inputs and per-stage control outputs of pipe_ctrl_unit.
// retired_cnt exists only when PIPE_CTRL_RETIRE_CNT_EN is defined.
interface pipe_ctrl_unit_if
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES   = 3,
    parameter int OPCODE_W = 4,
    parameter int FUNC_W   = 6,
    parameter int CNT_W    = 32
) ();
    logic                   id_valid;
    logic [OPCODE_W-1:0]    opcode;
    logic [FUNC_W-1:0]      func_code;
    logic                   mem_stall;
    logic                   hz_stall;
    logic                   flush;
    logic                   id_ready;
    logic [2:0]             branch_info;
    logic                   id_jrl_jpr;
    logic                   id_jxx;
    logic [STAGES*CW-1:0]   ctrl_pipe;
    logic                   retire;
    logic                   halted;
`ifdef PIPE_CTRL_RETIRE_CNT_EN
    logic [CNT_W-1:0]       retired_cnt;
`endif

    modport slave (
        input  id_valid, opcode, func_code, mem_stall, hz_stall, flush,
`ifdef PIPE_CTRL_RETIRE_CNT_EN
        output retired_cnt,
`endif
        output id_ready, branch_info, id_jrl_jpr, id_jxx, ctrl_pipe, retire, halted
    );

    modport master (
        output id_valid, opcode, func_code, mem_stall, hz_stall, flush,
`ifdef PIPE_CTRL_RETIRE_CNT_EN
        input  retired_cnt,
`endif
        input  id_ready, branch_info, id_jrl_jpr, id_jxx, ctrl_pipe, retire, halted
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode/func decode into a control word plus branch/jump hints.
// Undefined encodings yield an all-zero word (valid=0).
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int FUNC_W   = 6
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [FUNC_W-1:0]   func_code_i,
    output logic [CW-1:0]       ctrl_o,
    output logic [2:0]          branch_info_o,
    output logic                id_jrl_jpr_o,
    output logic                id_jxx_o
);
    logic is_rtype;
    logic is_branch;

    assign is_rtype      = (opcode_i == OPCODE_W'(OP_RTYPE));
    assign is_branch     = (opcode_i <= OPCODE_W'(OP_BLZ));
    assign branch_info_o = {is_branch, opcode_i[1:0]};
    assign id_jrl_jpr_o  = is_rtype && (func_code_i == FUNC_W'(FN_JPR) || func_code_i == FUNC_W'(FN_JRL));
    assign id_jxx_o      = id_jrl_jpr_o || (opcode_i == OPCODE_W'(OP_JAL));

    always_comb begin
        ctrl_o = '0;
        case (opcode_i)
            OPCODE_W'(OP_BNE), OPCODE_W'(OP_BEQ), OPCODE_W'(OP_BGZ), OPCODE_W'(OP_BLZ): begin
                ctrl_o[CTRL_VALID]       = 1'b1;
                ctrl_o[CTRL_ALUOP +: 2]  = ALU_FUNC;
            end
            OPCODE_W'(OP_ADI), OPCODE_W'(OP_ORI), OPCODE_W'(OP_LHI): begin
                ctrl_o[CTRL_VALID]       = 1'b1;
                ctrl_o[CTRL_REGWR]       = 1'b1;
                ctrl_o[CTRL_ALUSRC]      = 1'b1;
                ctrl_o[CTRL_ALUOP +: 2]  = (opcode_i == OPCODE_W'(OP_ADI)) ? ALU_ADD :
                                           (opcode_i == OPCODE_W'(OP_ORI)) ? ALU_OR  : ALU_LHI;
            end
            OPCODE_W'(OP_LWD): begin
                ctrl_o[CTRL_VALID]       = 1'b1;
                ctrl_o[CTRL_REGWR]       = 1'b1;
                ctrl_o[CTRL_MEM2REG]     = 1'b1;
                ctrl_o[CTRL_MEMRD]       = 1'b1;
                ctrl_o[CTRL_ALUSRC]      = 1'b1;
            end
            OPCODE_W'(OP_SWD): begin
                ctrl_o[CTRL_VALID]       = 1'b1;
                ctrl_o[CTRL_MEMWR]       = 1'b1;
                ctrl_o[CTRL_ALUSRC]      = 1'b1;
            end
            OPCODE_W'(OP_JMP): ctrl_o[CTRL_VALID] = 1'b1;
            OPCODE_W'(OP_JAL): begin
                ctrl_o[CTRL_VALID]       = 1'b1;
                ctrl_o[CTRL_REGWR]       = 1'b1;
                ctrl_o[CTRL_REGDST +: 2] = RD_R2;
                ctrl_o[CTRL_ALUOP +: 2]  = ALU_FUNC;
            end
            OPCODE_W'(OP_RTYPE): begin
                case (func_code_i)
                    FUNC_W'(FN_ADD), FUNC_W'(FN_SUB), FUNC_W'(FN_AND), FUNC_W'(FN_ORR),
                    FUNC_W'(FN_NOT), FUNC_W'(FN_TCP), FUNC_W'(FN_SHL), FUNC_W'(FN_SHR): begin
                        ctrl_o[CTRL_VALID]       = 1'b1;
                        ctrl_o[CTRL_REGWR]       = 1'b1;
                        ctrl_o[CTRL_REGDST +: 2] = RD_RD;
                        ctrl_o[CTRL_ALUOP +: 2]  = ALU_FUNC;
                    end
                    FUNC_W'(FN_WWD): begin
                        ctrl_o[CTRL_VALID]       = 1'b1;
                        ctrl_o[CTRL_WWD]         = 1'b1;
                        ctrl_o[CTRL_REGDST +: 2] = RD_RD;
                        ctrl_o[CTRL_ALUOP +: 2]  = ALU_FUNC;
                    end
                    FUNC_W'(FN_JRL): begin
                        ctrl_o[CTRL_VALID]       = 1'b1;
                        ctrl_o[CTRL_REGWR]       = 1'b1;
                        ctrl_o[CTRL_REGDST +: 2] = RD_R2;
                        ctrl_o[CTRL_ALUOP +: 2]  = ALU_FUNC;
                    end
                    FUNC_W'(FN_JPR): ctrl_o[CTRL_VALID] = 1'b1;
                    FUNC_W'(FN_HLT): begin
                        ctrl_o[CTRL_VALID]       = 1'b1;
                        ctrl_o[CTRL_HLT]         = 1'b1;
                    end
                    default: ctrl_o = '0;
                endcase
            end
            default: ctrl_o = '0;
        endcase
    end
endmodule

// File: rtl/pipe_ctrl_unit.sv
// Decodes ID into a control word and carries it through STAGES registered slices; HLT drains then halts.
// Latency: an accepted instruction sits in slice k after k+1 unfrozen cycles; retire is combinational from WB.
// Backpressure: mem_stall freezes all slices, hz_stall/flush/drain inject bubbles; retired_cnt via PIPE_CTRL_RETIRE_CNT_EN.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES   = 3,
    parameter int OPCODE_W = 4,
    parameter int FUNC_W   = 6,
    parameter int CNT_W    = 32
) (
    input  logic            clk,
    input  logic            reset,
    pipe_ctrl_unit_if.slave bus
);
    if (STAGES < 2 || STAGES > 5 || CNT_W < 1) begin : g_bad_cfg
        $error("pipe_ctrl_unit: STAGES must be 2..5 and CNT_W >= 1");
    end

    logic [CW-1:0]             dec_word;
    logic [CW-1:0]             wb;
    logic [STAGES-1:0][CW-1:0] stage_q, stage_d;
    halt_state_e               state_q;
    logic                      halted_q;
    logic                      accept;
    logic                      hlt_load;

    ctrl_decode #(.OPCODE_W(OPCODE_W), .FUNC_W(FUNC_W)) u_decode (
        .opcode_i      (bus.opcode),
        .func_code_i   (bus.func_code),
        .ctrl_o        (dec_word),
        .branch_info_o (bus.branch_info),
        .id_jrl_jpr_o  (bus.id_jrl_jpr),
        .id_jxx_o      (bus.id_jxx)
    );

    assign bus.id_ready  = !bus.mem_stall && !bus.hz_stall && (state_q == ST_RUN);
    assign accept        = bus.id_valid && bus.id_ready;
    assign hlt_load      = accept && !bus.flush && dec_word[CTRL_HLT];
    assign wb            = stage_q[STAGES-1];
    assign bus.retire    = wb[CTRL_VALID] && !bus.mem_stall;
    assign bus.ctrl_pipe = stage_q;
    assign bus.halted    = halted_q;

    // A flushed or non-accepted ID slot becomes an all-zero bubble in EX.
    always_comb begin
        stage_d = stage_q;
        if (!bus.mem_stall) begin
            stage_d[0] = (accept && !bus.flush) ? dec_word : '0;
            for (int k = 1; k < STAGES; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN:    if (hlt_load) state_q <= ST_DRAIN;
                ST_DRAIN:  if (wb[CTRL_VALID] && wb[CTRL_HLT] && !bus.mem_stall) begin
                               state_q  <= ST_HALTED;
                               halted_q <= 1'b1;
                           end
                ST_HALTED: state_q <= ST_HALTED;
                default:   state_q <= ST_RUN;
            endcase
        end
    end

`ifdef PIPE_CTRL_RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (bus.retire && !wb[CTRL_HLT] && state_q != ST_HALTED) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.retired_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit (STAGES=3): stimulus pushes expected WB words,
// a negedge monitor pops and compares them on every retire pulse.
module tb_pipe_ctrl_unit;
    import pipe_ctrl_pkg::*;

    localparam int ST = 3;

    // Hand-computed control words {v,hlt,wwd,rw,m2r,mr,mw,rd[1:0],aop[1:0],asrc}
    localparam logic [11:0] W_ADI = 12'h901;
    localparam logic [11:0] W_LWD = 12'h9C1;
    localparam logic [11:0] W_ORI = 12'h903;
    localparam logic [11:0] W_LHI = 12'h905;
    localparam logic [11:0] W_ADD = 12'h90E;
    localparam logic [11:0] W_HLT = 12'hC00;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_ctrl_unit_if #(.STAGES(ST), .OPCODE_W(4), .FUNC_W(6), .CNT_W(32)) bus ();

    pipe_ctrl_unit #(.STAGES(ST), .OPCODE_W(4), .FUNC_W(6), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int retire_seen = 0;
    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] exp_w;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] slice(input int k);
        logic [ST*CW-1:0] p;
        p = bus.ctrl_pipe;
        return p[k*CW +: CW];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [5:0] fn);
        bus.id_valid  = v;
        bus.opcode    = op;
        bus.func_code = fn;
    endtask

    // Scoreboard monitor: every retire must match the oldest outstanding word.
    always @(negedge clk) begin
        if (!reset && bus.retire) begin
            retire_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL retire_unexpected: got %h expected none", slice(ST-1));
            end else begin
                exp_w = exp_q.pop_front();
                chk("retire_word", slice(ST-1), exp_w);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 4'd0, 6'd0);
        bus.mem_stall = 1'b0;
        bus.hz_stall  = 1'b0;
        bus.flush     = 1'b0;
        repeat (2) cyc();
        chk("reset_pipe", bus.ctrl_pipe, '0);
        chk("reset_retire", bus.retire, 0);
        chk("reset_halted", bus.halted, 0);
        reset = 1'b0;

        // ADI flows through all slices and retires once
        drive(1'b1, OP_ADI, 6'd0); exp_q.push_back(W_ADI); #1;
        chk("adi_id_ready", bus.id_ready, 1);
        cyc(); chk("adi_slice0", slice(0), W_ADI); drive(1'b0, 4'd0, 6'd0);
        cyc(); chk("adi_slice1", slice(1), W_ADI);
        cyc(); chk("adi_slice2", slice(2), W_ADI);
        repeat (2) cyc();
        chk("adi_retire_once", retire_seen, 1);

        // LWD followed by a one-cycle load-use stall
        drive(1'b1, OP_LWD, 6'd0); exp_q.push_back(W_LWD);
        cyc(); chk("lwd_slice0", slice(0), W_LWD);
        drive(1'b1, OP_ORI, 6'd0); bus.hz_stall = 1'b1; #1;
        chk("hz_id_ready", bus.id_ready, 0);
        cyc(); chk("hz_bubble", slice(0), 0); chk("hz_lwd_slice1", slice(1), W_LWD);
        bus.hz_stall = 1'b0; exp_q.push_back(W_ORI);
        cyc(); chk("ori_late_slice0", slice(0), W_ORI);
        drive(1'b0, 4'd0, 6'd0);
        repeat (3) cyc();

        // Fill three stages, then freeze for three cycles with flush ignored
        drive(1'b1, OP_RTYPE, FN_ADD); exp_q.push_back(W_ADD); cyc();
        drive(1'b1, OP_LHI, 6'd0);     exp_q.push_back(W_LHI); cyc();
        drive(1'b1, OP_ADI, 6'd0);     exp_q.push_back(W_ADI); cyc();
        drive(1'b0, 4'd0, 6'd0);
        bus.mem_stall = 1'b1; bus.flush = 1'b1;
        chk("freeze_snapshot", bus.ctrl_pipe, {W_ADD, W_LHI, W_ADI});
        #1;
        chk("freeze_no_retire", bus.retire, 0);
        chk("freeze_id_ready", bus.id_ready, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("freeze_hold", bus.ctrl_pipe, {W_ADD, W_LHI, W_ADI});
        end
        bus.mem_stall = 1'b0; bus.flush = 1'b0;
        repeat (3) cyc();
`ifdef PIPE_CTRL_RETIRE_CNT_EN
        chk("cnt_after_freeze", bus.retired_cnt, 6);
`endif

        // Flush kills a valid SWD; no store may ever appear
        drive(1'b1, OP_SWD, 6'd0); bus.flush = 1'b1;
        cyc(); chk("flush_slice0", slice(0), 0);
        drive(1'b0, 4'd0, 6'd0); bus.flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("flush_no_memwr", bus.ctrl_pipe & {ST{12'h020}}, 0);
            cyc();
        end

        // Combinational branch/jump hints
        drive(1'b0, OP_BEQ, 6'd0); #1;
        chk("binfo_beq", bus.branch_info, 3'b101);
        drive(1'b0, OP_JAL, 6'd0); #1;
        chk("jxx_jal", {bus.id_jxx, bus.id_jrl_jpr}, 2'b10);
        drive(1'b0, OP_RTYPE, FN_JRL); #1;
        chk("jxx_jrl", {bus.id_jxx, bus.id_jrl_jpr}, 2'b11);
        cyc();

        // HLT with ADD held behind it
        drive(1'b1, OP_RTYPE, FN_HLT); exp_q.push_back(W_HLT); #1;
        chk("hlt_id_ready", bus.id_ready, 1);
        cyc(); chk("hlt_slice0", slice(0), W_HLT);
        drive(1'b1, OP_RTYPE, FN_ADD); #1;
        chk("drain_id_ready", bus.id_ready, 0);
        cyc(); chk("drain_add_blocked", slice(0), 0); chk("drain_halted2", bus.halted, 0);
        cyc(); chk("hlt_slice2", slice(2), W_HLT); chk("drain_halted3", bus.halted, 0);
        cyc(); chk("halted_at_4", bus.halted, 1);
`ifdef PIPE_CTRL_RETIRE_CNT_EN
        chk("cnt_excl_hlt", bus.retired_cnt, 6);
`endif
        repeat (2) cyc();
        chk("halted_pipe_empty", bus.ctrl_pipe, 0);
        chk("halted_sticky", bus.halted, 1);
        drive(1'b0, 4'd0, 6'd0);

        // Reset out of HALTED, enter DRAIN again, then reset mid-drain
        reset = 1'b1; cyc(); reset = 1'b0;
        drive(1'b1, OP_RTYPE, FN_HLT); exp_q.push_back(W_HLT);
        cyc(); drive(1'b0, 4'd0, 6'd0);
        cyc(); chk("pre_reset_slice1", slice(1), W_HLT);
        reset = 1'b1; exp_q.delete(); #1;
        chk("midreset_pipe", bus.ctrl_pipe, 0);
        chk("midreset_retire", bus.retire, 0);
        chk("midreset_halted", bus.halted, 0);
`ifdef PIPE_CTRL_RETIRE_CNT_EN
        chk("midreset_cnt", bus.retired_cnt, 0);
`endif
        cyc(); reset = 1'b0;
        drive(1'b1, OP_ADI, 6'd0); exp_q.push_back(W_ADI); #1;
        chk("post_reset_ready", bus.id_ready, 1);
        cyc(); chk("post_reset_slice0", slice(0), W_ADI);
        drive(1'b0, 4'd0, 6'd0);
        repeat (3) cyc();

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("total_retires", retire_seen, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
